// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: loads up to N unsigned 4-bit samples, bubble-sorts them in place
// with a single shared magnitude comparator (one compare per cycle), then streams
// the sorted entries out over a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset (control state only)
//   in_valid   load request; accepted when in_ready is high
//   in_data    4-bit sample to load
//   in_ready   high in IDLE while fewer than N entries are held
//   start      begin sorting the loaded entries (honoured in IDLE only)
//   busy       high while sorting or draining
//   out_valid  sorted entry available on out_data
//   out_data   current sorted entry (held while out_ready is low)
//   out_ready  consumer accepts out_data
//   done       one-cycle pulse after the last entry is accepted
//   swap_cnt   swaps performed by the most recent sort, saturating at 255

module comparator #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              a_gt_b,
  output logic              a_eq_b,
  output logic              a_lt_b
);
  assign a_gt_b = (a > b);
  assign a_eq_b = (a == b);
  assign a_lt_b = (a < b);
endmodule

module cmp_sort_ctrl #(
  parameter int N       = 8,
  parameter bit DESCEND = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  input  logic       start,
  output logic       busy,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready,
  output logic       done,
  output logic [7:0] swap_cnt
);
  localparam int DATA_W = 4;
  // At least two storage slots so mem[idx+1] is always a legal index, even for N=1.
  localparam int DEPTH  = (N < 2) ? 2 : N;
  localparam int IW     = $clog2(DEPTH);
  localparam int CW     = $clog2(N + 1);
  localparam logic [CW-1:0] N_C = CW'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SORT,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     count;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     lim;
  logic [IW-1:0]     rd;
  logic              pass_swap;

  logic [IW-1:0]     idx_p1;
  logic [DATA_W-1:0] cmp_a, cmp_b;
  logic              a_gt_b, a_eq_b, a_lt_b;

  logic              load_en;
  logic              start_acc;
  logic              cmp_en;
  logic              swap_en;
  logic              pass_end;
  logic              sort_end;
  logic              rd_acc;
  logic              last_acc;
  logic [CW-1:0]     count_eff;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign idx_p1 = idx + IW'(1);
  assign cmp_a  = mem[idx];
  assign cmp_b  = mem[idx_p1];

  comparator #(.DATA_W(DATA_W)) u_cmp (
    .a      (cmp_a),
    .b      (cmp_b),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .a_lt_b (a_lt_b)
  );

  // Next-state and per-cycle control decisions
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    start_acc = 1'b0;
    cmp_en    = 1'b0;
    swap_en   = 1'b0;
    pass_end  = 1'b0;
    sort_end  = 1'b0;
    rd_acc    = 1'b0;
    last_acc  = 1'b0;
    count_eff = count;
    case (state)
      S_IDLE: begin
        load_en   = in_valid && (count < N_C);
        // A load in the same cycle as start is part of the sort.
        count_eff = count + CW'(load_en);
        if (start && (count_eff != '0)) begin
          start_acc = 1'b1;
          state_nxt = S_SORT;
        end
      end
      S_SORT: begin
        // lim==0 means a single entry: one idle SORT cycle, no compare.
        cmp_en  = (lim != '0);
        // Equal entries never swap, which keeps the sort stable.
        swap_en = cmp_en && !a_eq_b && (DESCEND ? a_lt_b : a_gt_b);
        if (!cmp_en) begin
          sort_end = 1'b1;
        end else if (!(idx_p1 < lim)) begin
          pass_end = 1'b1;
          // The pass's own last compare counts toward "this pass swapped".
          if (!(pass_swap || swap_en) || (lim == IW'(1))) begin
            sort_end = 1'b1;
          end
        end
        if (sort_end) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        rd_acc   = out_ready;
        last_acc = out_ready && ((CW'(rd) + CW'(1)) == count);
        if (last_acc) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control registers: fill count, compare index, pass limit, read pointer, statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      idx       <= '0;
      lim       <= '0;
      rd        <= '0;
      pass_swap <= 1'b0;
      swap_cnt  <= 8'd0;
      done      <= 1'b0;
    end else begin
      done <= last_acc;
      if (load_en) begin
        count <= count + CW'(1);
      end
      if (start_acc) begin
        idx       <= '0;
        lim       <= IW'(count_eff - CW'(1));
        pass_swap <= 1'b0;
        swap_cnt  <= 8'd0;
      end
      if (swap_en) begin
        swap_cnt  <= sat_inc8(swap_cnt);
        pass_swap <= 1'b1;
      end
      if (cmp_en) begin
        if (pass_end) begin
          // Next pass starts immediately; the largest (or smallest) entry is now final.
          lim       <= lim - IW'(1);
          idx       <= '0;
          pass_swap <= 1'b0;
        end else begin
          idx <= idx_p1;
        end
      end
      if (rd_acc) begin
        rd <= last_acc ? '0 : rd + IW'(1);
      end
      if (last_acc) begin
        count <= '0;
      end
    end
  end

  // Sample storage: written by loads in IDLE and by swaps in SORT, never reset
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[count[IW-1:0]] <= in_data;
    end
    if (swap_en) begin
      mem[idx]    <= cmp_b;
      mem[idx_p1] <= cmp_a;
    end
  end

  assign in_ready  = (state == S_IDLE) && (count < N_C);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DRAIN);
  assign out_data  = out_valid ? mem[rd] : '0;

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
`timescale 1ns/1ps
module tb_cmp_sort_ctrl;
  typedef logic [3:0] q4_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, start, out_ready;
  logic [3:0] in_data;

  logic       a_in_ready, a_busy, a_out_valid, a_done;
  logic [3:0] a_out_data;
  logic [7:0] a_swap_cnt;
  logic       d_in_ready, d_busy, d_out_valid, d_done;
  logic [3:0] d_out_data;
  logic [7:0] d_swap_cnt;

  // Both instances see identical stimulus; sel_d picks which one is observed.
  logic       sel_d;
  logic       o_in_ready, o_busy, o_out_valid, o_done;
  logic [3:0] o_out_data;
  logic [7:0] o_swap_cnt;
  assign o_in_ready  = sel_d ? d_in_ready  : a_in_ready;
  assign o_busy      = sel_d ? d_busy      : a_busy;
  assign o_out_valid = sel_d ? d_out_valid : a_out_valid;
  assign o_done      = sel_d ? d_done      : a_done;
  assign o_out_data  = sel_d ? d_out_data  : a_out_data;
  assign o_swap_cnt  = sel_d ? d_swap_cnt  : a_swap_cnt;

  int vecs = 0;
  int errs = 0;

  cmp_sort_ctrl #(.N(8), .DESCEND(1'b0)) dut_asc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .start(start), .busy(a_busy), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(out_ready), .done(a_done), .swap_cnt(a_swap_cnt)
  );

  cmp_sort_ctrl #(.N(8), .DESCEND(1'b1)) dut_desc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(d_in_ready),
    .start(start), .busy(d_busy), .out_valid(d_out_valid), .out_data(d_out_data),
    .out_ready(out_ready), .done(d_done), .swap_cnt(d_swap_cnt)
  );

  // ---------------- reference model ----------------
  function automatic bit out_of_order(input logic [3:0] x, input logic [3:0] y, input bit desc);
    return desc ? (x < y) : (x > y);
  endfunction

  function automatic q4_t model_sorted(input q4_t v, input bit desc);
    q4_t r;
    r = {};
    for (int k = 0; k < 16; k++) begin
      int val;
      val = desc ? 15 - k : k;
      foreach (v[j]) if (int'(v[j]) == val) r.push_back(v[j]);
    end
    return r;
  endfunction

  // Bubble sort swaps exactly once per inverted pair.
  function automatic int model_swaps(input q4_t v, input bit desc);
    int s;
    s = 0;
    for (int j = 0; j < v.size(); j++)
      for (int i = 0; i < j; i++)
        if (out_of_order(v[i], v[j], desc)) s++;
    return s;
  endfunction

  // Passes needed = most out-of-order predecessors of any element, plus one clean
  // pass to notice sortedness, capped at n-1 passes; pass k covers n-1-k compares.
  function automatic int model_cycles(input q4_t v, input bit desc);
    int n, lmax, passes, cyc;
    n = v.size();
    if (n <= 1) return 1;
    lmax = 0;
    for (int j = 0; j < n; j++) begin
      int c;
      c = 0;
      for (int i = 0; i < j; i++) if (out_of_order(v[i], v[j], desc)) c++;
      if (c > lmax) lmax = c;
    end
    passes = (lmax + 1 < n - 1) ? lmax + 1 : n - 1;
    cyc = 0;
    for (int k = 0; k < passes; k++) cyc += n - 1 - k;
    return cyc;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b0; in_data = 4'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Load vals, start, measure SORT cycles, drain with stalls; returns observations.
  task automatic do_round(input q4_t vals, input bit concur, input bit drop,
                          input int first_stall, input int stall_pct,
                          output int cyc, output q4_t got, output int done_cnt,
                          output int done_next, output int stable_err,
                          output logic rdy_after, output bit tmo);
    int guard, stall_left;
    logic prev_stall;
    logic [3:0] prev_d;
    got = {}; cyc = 0; done_cnt = 0; done_next = 0; stable_err = 0; tmo = 1'b0;
    for (int k = 0; k < vals.size(); k++) begin
      in_valid = 1'b1; in_data = vals[k];
      if (concur && (k == vals.size() - 1)) start = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; start = 1'b0;
    end
    rdy_after = o_in_ready;
    if (drop) begin
      in_valid = 1'b1; in_data = 4'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    if (!concur) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    while (o_busy && !o_out_valid && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 300) tmo = 1'b1;
    guard = 0; stall_left = first_stall; prev_stall = 1'b0; prev_d = 4'd0;
    while (o_busy && !tmo) begin
      if (o_out_valid) begin
        if (prev_stall && (o_out_data !== prev_d)) stable_err++;
        if (stall_left > 0) begin
          out_ready = 1'b0; stall_left--;
        end else begin
          out_ready = ($urandom_range(0, 99) >= stall_pct);
        end
        prev_stall = !out_ready; prev_d = o_out_data;
        if (out_ready) got.push_back(o_out_data);
      end
      if (o_done) done_cnt++;
      @(negedge clk);
      guard++;
      if (guard > 400) tmo = 1'b1;
    end
    done_next = int'(o_done);
    for (int k = 0; k < 3; k++) begin
      if (o_done) done_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel_d = 1'b0;
    do_reset();
    @(negedge clk);
    vecs++; if (o_in_ready !== 1'b1) begin errs++; $display("FAIL reset in_ready: got %b want 1", o_in_ready); end
    vecs++; if (o_busy !== 1'b0) begin errs++; $display("FAIL reset busy: got %b want 0", o_busy); end
    vecs++; if (o_out_valid !== 1'b0) begin errs++; $display("FAIL reset out_valid: got %b want 0", o_out_valid); end
    vecs++; if (o_out_data !== 4'd0) begin errs++; $display("FAIL reset out_data: got %0d want 0", o_out_data); end
    vecs++; if (o_done !== 1'b0) begin errs++; $display("FAIL reset done: got %b want 0", o_done); end
    vecs++; if (o_swap_cnt !== 8'd0) begin errs++; $display("FAIL reset swap_cnt: got %0d want 0", o_swap_cnt); end
  endtask

  task automatic test_basic_sort();
    q4_t v, got, exp;
    int cyc, dc, dn, se; logic ra; bit tmo;
    sel_d = 1'b0; do_reset();
    v = {4'd3, 4'd5, 4'd8, 4'd2}; exp = {4'd2, 4'd3, 4'd5, 4'd8};
    do_round(v, 1'b0, 1'b0, 0, 30, cyc, got, dc, dn, se, ra, tmo);
    vecs++; if (tmo) begin errs++; $display("FAIL basic timeout: got 1 want 0"); end
    vecs++; if (cyc != 6) begin errs++; $display("FAIL basic sort_cycles: got %0d want 6", cyc); end
    vecs++; if (got.size() != 4) begin errs++; $display("FAIL basic drain_len: got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      vecs++; if (got[k] !== exp[k]) begin errs++; $display("FAIL basic drain[%0d]: got %0d want %0d", k, got[k], exp[k]); end
    end
    vecs++; if (o_swap_cnt !== 8'd3) begin errs++; $display("FAIL basic swap_cnt: got %0d want 3", o_swap_cnt); end
    vecs++; if (dc != 1 || dn != 1) begin errs++; $display("FAIL basic done: got pulses=%0d next=%0d want 1/1", dc, dn); end
    vecs++; if (se != 0) begin errs++; $display("FAIL basic hold: got %0d changes want 0", se); end
  endtask

  task automatic test_equal_values();
    q4_t v, got, exp;
    int cyc, dc, dn, se; logic ra; bit tmo;
    sel_d = 1'b0; do_reset();
    v = {4'd7, 4'd7, 4'd9, 4'd9}; exp = {4'd7, 4'd7, 4'd9, 4'd9};
    do_round(v, 1'b0, 1'b0, 0, 0, cyc, got, dc, dn, se, ra, tmo);
    vecs++; if (tmo) begin errs++; $display("FAIL equal timeout: got 1 want 0"); end
    vecs++; if (cyc != 3) begin errs++; $display("FAIL equal sort_cycles: got %0d want 3", cyc); end
    vecs++; if (got.size() != 4) begin errs++; $display("FAIL equal drain_len: got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      vecs++; if (got[k] !== exp[k]) begin errs++; $display("FAIL equal drain[%0d]: got %0d want %0d", k, got[k], exp[k]); end
    end
    vecs++; if (o_swap_cnt !== 8'd0) begin errs++; $display("FAIL equal swap_cnt: got %0d want 0", o_swap_cnt); end
  endtask

  task automatic test_full_buffer();
    q4_t v, got;
    int cyc, dc, dn, se; logic ra; bit tmo;
    sel_d = 1'b0; do_reset();
    v = {4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
    do_round(v, 1'b0, 1'b1, 0, 20, cyc, got, dc, dn, se, ra, tmo);
    vecs++; if (tmo) begin errs++; $display("FAIL full timeout: got 1 want 0"); end
    vecs++; if (ra !== 1'b0) begin errs++; $display("FAIL full in_ready: got %b want 0", ra); end
    vecs++; if (cyc != 28) begin errs++; $display("FAIL full sort_cycles: got %0d want 28", cyc); end
    vecs++; if (got.size() != 8) begin errs++; $display("FAIL full drain_len: got %0d want 8", got.size()); end
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      vecs++; if (got[k] !== 4'(8 + k)) begin errs++; $display("FAIL full drain[%0d]: got %0d want %0d", k, got[k], 8 + k); end
    end
    vecs++; if (o_swap_cnt !== 8'd28) begin errs++; $display("FAIL full swap_cnt: got %0d want 28", o_swap_cnt); end
  endtask

  task automatic test_descend_stall();
    q4_t v, got, exp;
    int cyc, dc, dn, se; logic ra; bit tmo;
    sel_d = 1'b1; do_reset();
    v = {4'd0, 4'd1, 4'd9}; exp = {4'd9, 4'd1, 4'd0};
    do_round(v, 1'b0, 1'b0, 5, 0, cyc, got, dc, dn, se, ra, tmo);
    vecs++; if (tmo) begin errs++; $display("FAIL desc timeout: got 1 want 0"); end
    vecs++; if (cyc != 3) begin errs++; $display("FAIL desc sort_cycles: got %0d want 3", cyc); end
    vecs++; if (se != 0) begin errs++; $display("FAIL desc hold: got %0d changes want 0", se); end
    vecs++; if (got.size() != 3) begin errs++; $display("FAIL desc drain_len: got %0d want 3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      vecs++; if (got[k] !== exp[k]) begin errs++; $display("FAIL desc drain[%0d]: got %0d want %0d", k, got[k], exp[k]); end
    end
    vecs++; if (o_swap_cnt !== 8'd3) begin errs++; $display("FAIL desc swap_cnt: got %0d want 3", o_swap_cnt); end
  endtask

  task automatic test_reset_mid_sort();
    q4_t v, got;
    int cyc, dc, dn, se; logic ra; bit tmo;
    sel_d = 1'b0; do_reset();
    v = {4'd3, 4'd5, 4'd8, 4'd2};
    foreach (v[k]) begin
      in_valid = 1'b1; in_data = v[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    vecs++; if (o_busy !== 1'b1) begin errs++; $display("FAIL midrst busy_before: got %b want 1", o_busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vecs++; if ({o_in_ready, o_busy, o_out_valid, o_done} !== 4'b1000)
      begin errs++; $display("FAIL midrst flags: got %b want 1000", {o_in_ready, o_busy, o_out_valid, o_done}); end
    vecs++; if (o_out_data !== 4'd0 || o_swap_cnt !== 8'd0)
      begin errs++; $display("FAIL midrst data: got %0d/%0d want 0/0", o_out_data, o_swap_cnt); end
    v = {4'd4, 4'd1};
    do_round(v, 1'b0, 1'b0, 0, 40, cyc, got, dc, dn, se, ra, tmo);
    vecs++; if (tmo || got.size() != 2) begin errs++; $display("FAIL midrst reload_len: got %0d want 2", got.size()); end
    else begin
      vecs++; if (got[0] !== 4'd1 || got[1] !== 4'd4) begin errs++; $display("FAIL midrst reload: got %0d,%0d want 1,4", got[0], got[1]); end
    end
  endtask

  task automatic test_empty_and_single();
    q4_t v, got;
    int cyc, dc, dn, se; logic ra; bit tmo;
    sel_d = 1'b0; do_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    vecs++; if (o_busy !== 1'b0 || o_in_ready !== 1'b1) begin errs++; $display("FAIL empty start: got busy=%b rdy=%b want 0/1", o_busy, o_in_ready); end
    @(negedge clk);
    vecs++; if (o_busy !== 1'b0) begin errs++; $display("FAIL empty idle: got busy=%b want 0", o_busy); end
    v = {4'd6};
    do_round(v, 1'b0, 1'b0, 0, 0, cyc, got, dc, dn, se, ra, tmo);
    vecs++; if (tmo) begin errs++; $display("FAIL single timeout: got 1 want 0"); end
    vecs++; if (cyc != 1) begin errs++; $display("FAIL single sort_cycles: got %0d want 1", cyc); end
    vecs++; if (got.size() != 1 || got[0] !== 4'd6) begin errs++; $display("FAIL single drain: got len %0d want 1 entry of 6", got.size()); end
    vecs++; if (dc != 1) begin errs++; $display("FAIL single done: got %0d pulses want 1", dc); end
  endtask

  task automatic test_back_to_back();
    q4_t v, got, exp;
    int cyc, dc, dn, se; logic ra; bit tmo;
    sel_d = 1'b0; do_reset();
    for (int r = 0; r < 2; r++) begin
      if (r == 0) v = {4'd9, 4'd2, 4'd5};
      else        v = {4'd1, 4'd0};
      exp = model_sorted(v, 1'b0);
      do_round(v, r == 1, 1'b0, 0, 25, cyc, got, dc, dn, se, ra, tmo);
      vecs++; if (tmo || cyc != model_cycles(v, 1'b0))
        begin errs++; $display("FAIL b2b[%0d] sort_cycles: got %0d want %0d", r, cyc, model_cycles(v, 1'b0)); end
      vecs++; if (got != exp) begin errs++; $display("FAIL b2b[%0d] drain: got %p want %p", r, got, exp); end
      vecs++; if (int'(o_swap_cnt) != model_swaps(v, 1'b0))
        begin errs++; $display("FAIL b2b[%0d] swap_cnt: got %0d want %0d", r, o_swap_cnt, model_swaps(v, 1'b0)); end
    end
  endtask

  task automatic test_random();
    q4_t v, got, exp;
    int cyc, dc, dn, se, n, ecyc, esw; logic ra; bit tmo, ns, concur;
    for (int r = 0; r < 14; r++) begin
      ns = 1'($urandom_range(0, 1));
      if (r == 0 || ns != sel_d) begin
        sel_d = ns; do_reset();
      end
      n = $urandom_range(1, 8);
      v = {};
      for (int k = 0; k < n; k++) v.push_back(4'($urandom_range(0, 15)));
      concur = 1'($urandom_range(0, 1));
      exp = model_sorted(v, sel_d); ecyc = model_cycles(v, sel_d); esw = model_swaps(v, sel_d);
      do_round(v, concur, 1'b0, 0, $urandom_range(0, 60), cyc, got, dc, dn, se, ra, tmo);
      vecs++; if (tmo) begin errs++; $display("FAIL rand[%0d] timeout: got 1 want 0", r); end
      vecs++; if (cyc != ecyc) begin errs++; $display("FAIL rand[%0d] sort_cycles: got %0d want %0d", r, cyc, ecyc); end
      vecs++; if (got != exp) begin errs++; $display("FAIL rand[%0d] drain: got %p want %p", r, got, exp); end
      vecs++; if (int'(o_swap_cnt) != esw) begin errs++; $display("FAIL rand[%0d] swap_cnt: got %0d want %0d", r, o_swap_cnt, esw); end
      vecs++; if (dc != 1 || dn != 1) begin errs++; $display("FAIL rand[%0d] done: got pulses=%0d next=%0d want 1/1", r, dc, dn); end
      vecs++; if (se != 0) begin errs++; $display("FAIL rand[%0d] hold: got %0d changes want 0", r, se); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b0; in_data = 4'd0; sel_d = 1'b0;
    test_reset();
    test_basic_sort();
    test_equal_values();
    test_full_buffer();
    test_descend_stall();
    test_reset_mid_sort();
    test_empty_and_single();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
